// File: rtl/game_screen_sequencer.sv
// Sequences full-screen generators onto the OLED pixel path with frame-aligned transitions; SCREEN_WIPE_EN selects wipe vs hard cut.
// oled_data latency 1 cycle; no backpressure (requests arriving mid-transition are dropped, game_over cuts immediately).
module game_screen_sequencer #(
  parameter int NUM_SCREENS   = 4,
  parameter int GAMEOVER_IDX  = 3,
  parameter int SPLASH_FRAMES = 120,
  parameter int WIPE_STEP     = 8,
  parameter int SCREEN_W      = 96
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_begin,
  input  logic        btn_next,
  input  logic        btn_back,
  input  logic        game_over,
  input  logic [6:0]  x,
  input  logic [15:0] screen_data_0,
  input  logic [15:0] screen_data_1,
  input  logic [15:0] screen_data_2,
  input  logic [15:0] screen_data_3,
  output logic [15:0] oled_data,
  output logic [1:0]  screen_sel,
  output logic        busy
);

  if (NUM_SCREENS < 2 || NUM_SCREENS > 4 || GAMEOVER_IDX < 0 || GAMEOVER_IDX >= NUM_SCREENS ||
      SPLASH_FRAMES < 1 || SPLASH_FRAMES > 255 || WIPE_STEP < 1 || WIPE_STEP > 96 ||
      SCREEN_W < 1 || SCREEN_W > 128) begin : g_bad_params
    $error("game_screen_sequencer: parameter out of range");
  end

  localparam logic [1:0] LAST_IDX    = 2'(NUM_SCREENS - 1);
  localparam logic [1:0] GO_IDX      = 2'(GAMEOVER_IDX);
  localparam logic [7:0] SPLASH_LAST = 8'(SPLASH_FRAMES - 1);

`ifdef SCREEN_WIPE_EN
  typedef enum logic [1:0] {SPLASH, SHOW, ARMED, WIPE} state_t;
  localparam logic [8:0] STEP9     = 9'(WIPE_STEP);
  localparam logic [8:0] SCREEN_W9 = 9'(SCREEN_W);
`else
  typedef enum logic [1:0] {SPLASH, SHOW, ARMED} state_t;
`endif

  state_t      state;
  logic [1:0]  cur;
  logic [1:0]  target;
  logic [7:0]  frame_cnt;
  logic [1:0]  pix_sel;
  logic [15:0] pix;
  logic        commit;

  function automatic logic [1:0] idx_up(input logic [1:0] i);
    return (i == LAST_IDX) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [1:0] idx_down(input logic [1:0] i);
    return (i == 2'd0) ? LAST_IDX : i - 2'd1;
  endfunction

`ifdef SCREEN_WIPE_EN
  logic [7:0] wipe_col;
  logic [8:0] wipe_nxt;

  // 9 bits: col < SCREEN_W plus a step <= 96 cannot wrap
  assign wipe_nxt = {1'b0, wipe_col} + STEP9;
  assign commit   = (state == WIPE) && frame_begin && (wipe_nxt >= SCREEN_W9);

  always_comb begin
    pix_sel = cur;
    if (state == WIPE && {1'b0, x} < wipe_col) pix_sel = target;
  end
`else
  logic x_unused;

  assign x_unused = ^x;
  assign commit   = (state == ARMED) && frame_begin;
  assign pix_sel  = cur;
`endif

  always_comb begin
    pix = 16'h0000;
    case (pix_sel)
      2'd0:    pix = screen_data_0;
      2'd1:    if (NUM_SCREENS > 1) pix = screen_data_1;
      2'd2:    if (NUM_SCREENS > 2) pix = screen_data_2;
      default: if (NUM_SCREENS > 3) pix = screen_data_3;
    endcase
  end

  assign screen_sel = cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SPLASH;
      cur       <= 2'd0;
      target    <= 2'd0;
      frame_cnt <= 8'd0;
      busy      <= 1'b0;
      oled_data <= 16'h0000;
`ifdef SCREEN_WIPE_EN
      wipe_col  <= 8'd0;
`endif
    end else begin
      oled_data <= pix;
      if (game_over) begin
        // deliberate mid-frame cut: game-over must show at once
        cur       <= GO_IDX;
        target    <= 2'd0;
        state     <= SHOW;
        busy      <= 1'b0;
        frame_cnt <= 8'd0;
`ifdef SCREEN_WIPE_EN
        wipe_col  <= 8'd0;
`endif
      end else begin
        case (state)
          SPLASH: begin
            if (btn_next || (frame_begin && frame_cnt == SPLASH_LAST)) begin
              target <= 2'd1;
              state  <= ARMED;
              busy   <= 1'b1;
            end else if (frame_begin) begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
          SHOW: begin
            if (btn_next != btn_back) begin
              target <= btn_next ? idx_up(cur) : idx_down(cur);
              state  <= ARMED;
              busy   <= 1'b1;
            end
          end
`ifdef SCREEN_WIPE_EN
          ARMED: begin
            if (frame_begin) begin
              wipe_col <= 8'd0;
              state    <= WIPE;
            end
          end
          WIPE: begin
            if (frame_begin) wipe_col <= wipe_nxt[7:0];
          end
`endif
          default: ;
        endcase

        if (commit) begin
          cur  <= target;
          busy <= 1'b0;
`ifdef SCREEN_WIPE_EN
          wipe_col <= 8'd0;
`endif
          if (target == 2'd0) begin
            state     <= SPLASH;
            frame_cnt <= 8'd0;
          end else begin
            state <= SHOW;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_game_screen_sequencer.sv
// Bench for game_screen_sequencer: directed stimulus, screen-level reference model checked every cycle, plus literal spot checks.
module tb_game_screen_sequencer;

  localparam int N        = 4;
  localparam int GO_IDX   = 3;
  localparam int SPLASH_N = 120;
  localparam int STEP     = 8;
  localparam int W        = 96;
`ifdef SCREEN_WIPE_EN
  localparam bit WIPE_EN  = 1'b1;
`else
  localparam bit WIPE_EN  = 1'b0;
`endif
  // arming frame plus ceil(96/8) = 12 wipe frames, or a single cut frame
  localparam int COMMIT_FRAMES = WIPE_EN ? 13 : 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_begin, btn_next, btn_back, game_over;
  logic [6:0]  x;
  logic [15:0] sd [4];
  logic [15:0] oled_data;
  logic [1:0]  screen_sel;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit fix_sd = 1'b0;

  // reference model: what is on screen, what is requested, how far the wipe has got
  int          m_cur, m_tgt, m_frames, m_wframes;
  bit          m_splash, m_pend, m_wiping;
  logic [15:0] exp_oled;

  game_screen_sequencer #(
    .NUM_SCREENS(N), .GAMEOVER_IDX(GO_IDX), .SPLASH_FRAMES(SPLASH_N),
    .WIPE_STEP(STEP), .SCREEN_W(W)
  ) dut (
    .clk(clk), .rst(rst), .frame_begin(frame_begin), .btn_next(btn_next),
    .btn_back(btn_back), .game_over(game_over), .x(x),
    .screen_data_0(sd[0]), .screen_data_1(sd[1]), .screen_data_2(sd[2]), .screen_data_3(sd[3]),
    .oled_data(oled_data), .screen_sel(screen_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cur = 0; m_tgt = 0; m_frames = 0; m_wframes = 0;
    m_splash = 1'b1; m_pend = 1'b0; m_wiping = 1'b0;
    exp_oled = 16'h0000;
  endtask

  task automatic model_commit();
    m_cur = m_tgt; m_pend = 1'b0; m_wiping = 1'b0;
    if (m_cur == 0) begin
      m_splash = 1'b1;
      m_frames = 0;
    end
  endtask

  task automatic model_edge(input bit fb, input bit nx, input bit bk, input bit go, input int xv);
    int col;
    col = m_wiping ? m_wframes * STEP : 0;
    exp_oled = sd[(m_wiping && xv < col) ? m_tgt : m_cur];
    if (go) begin
      m_cur = GO_IDX; m_tgt = 0; m_splash = 1'b0; m_pend = 1'b0; m_wiping = 1'b0;
    end else if (m_wiping) begin
      if (fb) begin
        m_wframes++;
        if (m_wframes * STEP >= W) model_commit();
      end
    end else if (m_pend) begin
      if (fb) begin
        if (WIPE_EN) begin
          m_pend = 1'b0; m_wiping = 1'b1; m_wframes = 0;
        end else begin
          model_commit();
        end
      end
    end else if (m_splash) begin
      if (nx) begin
        m_tgt = 1; m_pend = 1'b1; m_splash = 1'b0;
      end else if (fb) begin
        m_frames++;
        if (m_frames == SPLASH_N) begin
          m_tgt = 1; m_pend = 1'b1; m_splash = 1'b0;
        end
      end
    end else if (nx != bk) begin
      m_tgt  = (m_cur + (nx ? 1 : N - 1)) % N;
      m_pend = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_oled", 32'(oled_data), 32'(exp_oled));
      chk("cyc_sel",  32'(screen_sel), 32'(m_cur));
      chk("cyc_busy", 32'(busy), 32'(m_pend || m_wiping));
    end
  end

  task automatic step(input bit fb, input bit nx, input bit bk, input bit go, input int xv);
    frame_begin = fb; btn_next = nx; btn_back = bk; game_over = go; x = 7'(xv);
    if (!fix_sd) for (int i = 0; i < 4; i++) sd[i] = 16'($urandom);
    @(posedge clk);
    model_edge(fb, nx, bk, go, xv);
    #1;
    frame_begin = 1'b0; btn_next = 1'b0; btn_back = 1'b0; game_over = 1'b0;
  endtask

  task automatic frame();
    step(1'b1, 1'b0, 1'b0, 1'b0, int'($urandom_range(95, 0)));
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, int'($urandom_range(95, 0)));
  endtask

  task automatic wait_commit(input int expect_frames, input string name);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      frame();
      n++;
      if (busy === 1'b0) break;
    end
    chk(name, 32'(n), 32'(expect_frames));
  endtask

  initial begin
    rst = 1'b1;
    frame_begin = 1'b0; btn_next = 1'b0; btn_back = 1'b0; game_over = 1'b0; x = 7'd0;
    for (int i = 0; i < 4; i++) sd[i] = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_oled", 32'(oled_data), 32'h0);
    chk("rst_sel",  32'(screen_sel), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // splash holds for 119 frames, arms on the 120th, then commits to screen 1
    for (int i = 1; i < SPLASH_N; i++) frame();
    chk("splash_hold_busy", 32'(busy), 32'h0);
    chk("splash_hold_sel",  32'(screen_sel), 32'h0);
    frame();
    chk("splash_armed_busy", 32'(busy), 32'h1);
    wait_commit(COMMIT_FRAMES, "commit_auto");
    chk("sel_after_auto", 32'(screen_sel), 32'h1);

    // pixel path: exactly one clock of latency
    fix_sd = 1'b1; sd[1] = 16'h07E0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 10);
    chk("pix_latency", 32'(oled_data), 32'h07E0);
    fix_sd = 1'b0;

    // simultaneous next+back is ignored
    step(1'b0, 1'b1, 1'b1, 1'b0, 3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4);
    chk("both_btn_busy", 32'(busy), 32'h0);
    chk("both_btn_sel",  32'(screen_sel), 32'h1);

    // 1 -> 2, with a dropped second request while armed
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("next_busy", 32'(busy), 32'h1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
`ifdef SCREEN_WIPE_EN
    repeat (4) frame();
    fix_sd = 1'b1; sd[1] = 16'h1111; sd[2] = 16'h2222;
    step(1'b0, 1'b0, 1'b0, 1'b0, 23);
    chk("wipe_x23", 32'(oled_data), 32'h2222);
    step(1'b0, 1'b0, 1'b0, 1'b0, 24);
    chk("wipe_x24", 32'(oled_data), 32'h1111);
    fix_sd = 1'b0;
    wait_commit(9, "commit_2");
`else
    wait_commit(1, "commit_2");
`endif
    chk("sel_2", 32'(screen_sel), 32'h2);

    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    wait_commit(COMMIT_FRAMES, "commit_3");
    chk("sel_3", 32'(screen_sel), 32'h3);

    // 3 -> 0 wraps and re-enters splash with a fresh frame count
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    wait_commit(COMMIT_FRAMES, "commit_wrap0");
    chk("sel_wrap0", 32'(screen_sel), 32'h0);
    for (int i = 1; i < SPLASH_N; i++) frame();
    chk("resplash_hold_busy", 32'(busy), 32'h0);
    frame();
    chk("resplash_armed_busy", 32'(busy), 32'h1);
    wait_commit(COMMIT_FRAMES, "commit_auto2");
    chk("sel_auto2", 32'(screen_sel), 32'h1);

    // back 1 -> 0, back ignored in splash, next skips the splash wait
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    wait_commit(COMMIT_FRAMES, "commit_back0");
    chk("sel_back0", 32'(screen_sel), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("splash_back_ignored", 32'(busy), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("splash_skip_busy", 32'(busy), 32'h1);
    wait_commit(COMMIT_FRAMES, "commit_skip");
    chk("sel_skip", 32'(screen_sel), 32'h1);

    // game_over mid-transition (wipe column 40), coincident with a button
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    if (WIPE_EN) repeat (6) frame();
    step(1'b0, 1'b1, 1'b0, 1'b1, 0);
    chk("go_sel",  32'(screen_sel), 32'h3);
    chk("go_busy", 32'(busy), 32'h0);
    fix_sd = 1'b1; sd[3] = 16'h3C3C;
    step(1'b0, 1'b0, 1'b0, 1'b0, 5);
    chk("go_oled", 32'(oled_data), 32'h3C3C);
    fix_sd = 1'b0;

    // back from 3 -> 2
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    wait_commit(COMMIT_FRAMES, "commit_back2");
    chk("sel_back2", 32'(screen_sel), 32'h2);

    // asynchronous reset in the middle of a transition
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    if (WIPE_EN) repeat (3) frame();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_mid_sel",  32'(screen_sel), 32'h0);
    chk("rst_mid_oled", 32'(oled_data), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) frame();
    chk("post_rst_sel", 32'(screen_sel), 32'h0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
